coin_change_dispenser: RTL
==========================

Name: coin_change_dispenser

Overview:
- Drives the coin ejector when the machine returns change. It uses the same 2-bit coin code that the coin intake decodes: 01 = 1, 10 = 5, 11 = 10, 00 = no coin.
- Takes a change amount and breaks it down greedily into 10/5/1 coins, skipping any denomination whose tube is empty.
- Emits one coin code per pulse, with a mandatory 00 gap between pulses so that every coin is a distinct 00->code edge.
- Sits between the transaction controller (start, amount, done) and the ejector/tube sensors.

Parameters:
AMT_W, 8, width of amount and remaining.
PULSE_CYCLES, 2, cycles each coin code is held on coin_out; must be >=1.
GAP_CYCLES, 2, minimum cycles coin_out is held at 00 after each pulse; must be >=1.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous reset, active-low
start  input  1  request to dispense; sampled only in IDLE
amount  input  AMT_W  change value in units of 1; latched on accepted start
empty_10  input  1  10-coin tube empty
empty_5  input  1  5-coin tube empty
empty_1  input  1  1-coin tube empty
coin_out  output  2  coin code to ejector (00/01/10/11)
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle completion pulse
short  output  1  valid with done; 1 = amount could not be fully paid
remaining  output  AMT_W  unpaid amount; valid with done, held until the next accepted start

Behaviour:
- Reset (synchronous, rst_n low at a rising edge): state = IDLE, coin_out = 00, busy = 0, done = 0, short = 0, remaining = 0, internal rem = 0, timer = 0.
- Reset overrides everything, including mid-pulse: coin_out returns to 00 on that edge and no completion pulse is issued.
- All outputs are registered.
- State IDLE:
  - busy = 0.
  - On start = 1: rem <= amount, then go to SELECT.
  - start is ignored in every other state; there is no queueing.
- State SELECT (one cycle):
  - Denomination priority is 10, then 5, then 1. Choose the first d with rem >= d and that tube not empty.
  - Empty flags are sampled only in this cycle.
  - If a d is chosen: coin_out <= code(d), rem <= rem - d, timer <= PULSE_CYCLES-1, then go to PULSE.
  - If rem == 0: go to FINISH with short = 0.
  - If rem > 0 and no eligible d: go to FINISH with short = 1.
- State PULSE:
  - coin_out is held.
  - When timer == 0: coin_out <= 00, timer <= GAP_CYCLES-1, then go to GAP.
  - Otherwise timer decrements.
- State GAP:
  - coin_out = 00.
  - When timer == 0: go to SELECT. Otherwise timer decrements.
- State FINISH (one cycle):
  - done = 1, remaining = rem, short as decided in SELECT, busy = 1.
  - Next state IDLE.
  - done and short drop to 0 the following cycle.
- Timing:
  - Start sampled at edge k: SELECT at k+1, coin_out non-zero from edge k+2.
  - Each coin code is non-zero for exactly PULSE_CYCLES cycles.
  - 00 lasts at least GAP_CYCLES+1 cycles between coins (GAP plus SELECT).
  - Per-coin period = 1 + PULSE_CYCLES + GAP_CYCLES.
- amount = 0: IDLE -> SELECT -> FINISH, done 2 cycles after start, no coin emitted, short = 0.
- Fallback: a larger empty denomination falls back to smaller ones. Example: empty_10 with rem = 20 pays four 5-coins.
- Arithmetic:
  - rem is unsigned AMT_W bits.
  - Subtraction occurs only when rem >= d, so there is no wrap-around.
  - The maximum amount 2^AMT_W-1 is supported.
- Empty flag asserting mid-pulse: does not abort the current coin; it takes effect at the next SELECT.

Test Plan:
1. Defaults, amount = 16, all tubes full, start pulse.
   - coin_out sequence 11, 10, 01, each code for 2 cycles with >=3 cycles of 00 between.
   - First non-zero code 2 cycles after start.
   - done once with short = 0, remaining = 0; busy falls with IDLE.
2. amount = 0.
   - No non-zero coin_out; done 2 cycles after start, short = 0.
3. amount = 7, empty_5 = 1.
   - Seven 01 pulses, each separated by 00; done with short = 0.
4. amount = 12, empty_1 = 1.
   - One 11 pulse, then done with short = 1, remaining = 2.
5. Busy and reset behaviour, amount = 255:
   - Expected output is twenty-five 11 pulses then one 10.
   - start with amount = 5 pulsed while busy is ignored; the coin count is unchanged.
   - Repeat with rst_n low during the 3rd pulse: coin_out = 00, busy = 0, done = 0 after that edge.
   - A subsequent start dispenses normally.
6. empty_10 asserted during the first 11 pulse of amount = 30.
   - The current 11 pulse completes; the remainder is paid as 10, 10, 10, 10; done with short = 0.

Source files
------------

// File: rtl/coin_change_dispenser.sv
// Change dispenser: splits a change amount greedily into 10/5/1 coins and
// pulses one 2-bit coin code at a time, with a 00 gap between coins.
module coin_change_dispenser #(
    parameter int AMT_W        = 8,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             empty_10,
    input  logic             empty_5,
    input  logic             empty_1,
    output logic [1:0]       coin_out,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] remaining
);

    localparam int TMAX  = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TMR_W = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_CYCLES - 1);
    localparam logic [AMT_W-1:0] D10 = AMT_W'(10);
    localparam logic [AMT_W-1:0] D5  = AMT_W'(5);
    localparam logic [AMT_W-1:0] D1  = AMT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        PULSE,
        GAP,
        FINISH
    } state_t;

    state_t           state_q;
    logic [AMT_W-1:0] rem_q;
    logic [TMR_W-1:0] timer_q;
    logic [1:0]       coin_q;
    logic             busy_q;
    logic             done_q;
    logic             short_q;
    logic [AMT_W-1:0] remaining_q;

    logic             sel_ok;
    logic [1:0]       sel_code;
    logic [AMT_W-1:0] sel_val;

    // Greedy pick, largest denomination first, skipping empty tubes.
    always_comb begin
        sel_ok   = 1'b1;
        sel_code = 2'b00;
        sel_val  = '0;
        if (rem_q >= D10 && !empty_10) begin
            sel_code = 2'b11;
            sel_val  = D10;
        end else if (rem_q >= D5 && !empty_5) begin
            sel_code = 2'b10;
            sel_val  = D5;
        end else if (rem_q >= D1 && !empty_1) begin
            sel_code = 2'b01;
            sel_val  = D1;
        end else begin
            sel_ok = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            timer_q     <= '0;
            coin_q      <= 2'b00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            short_q     <= 1'b0;
            remaining_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rem_q   <= amount;
                        busy_q  <= 1'b1;
                        state_q <= SELECT;
                    end
                end
                SELECT: begin
                    if (sel_ok) begin
                        coin_q  <= sel_code;
                        rem_q   <= rem_q - sel_val;
                        timer_q <= PULSE_LOAD;
                        state_q <= PULSE;
                    end else begin
                        // Nothing payable: either paid in full or stuck short.
                        done_q      <= 1'b1;
                        short_q     <= (rem_q != '0);
                        remaining_q <= rem_q;
                        state_q     <= FINISH;
                    end
                end
                PULSE: begin
                    if (timer_q == '0) begin
                        coin_q  <= 2'b00;
                        timer_q <= GAP_LOAD;
                        state_q <= GAP;
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end
                GAP: begin
                    if (timer_q == '0) begin
                        state_q <= SELECT;
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end
                FINISH: begin
                    done_q  <= 1'b0;
                    short_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign coin_out  = coin_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign short     = short_q;
    assign remaining = remaining_q;

endmodule
